// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-FF synchronizer, debounce counter, debounced level,
// and one-cycle press / release / long-press pulses in the clk_in domain.
module button_conditioner #(
    parameter bit          ACTIVE_LOW        = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES   = 1_250_000,
    parameter int unsigned LONG_PRESS_CYCLES = 125_000_000
) (
    input  logic clk_in,
    input  logic reset,
    input  logic button_raw,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse,
    output logic long_held
);

    localparam int unsigned     DebW        = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned     HoldW       = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [DebW-1:0] DebLast     = DebW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldMax    = HoldW'(LONG_PRESS_CYCLES);
    localparam logic [HoldW-1:0] HoldOne    = HoldW'(1);
    // Pin level seen while the button is not pressed.
    localparam logic            PinReleased = ACTIVE_LOW;

    logic             sync1_q, sync2_q;
    logic             norm;
    logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
    logic             pressed_q, pressed_d;
    logic             press_pulse_q, press_pulse_d;
    logic             release_pulse_q, release_pulse_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic             long_pulse_q, long_pulse_d;
    logic             long_held_q, long_held_d;

    // Two-stage synchronizer; resets to the released pin level.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync1_q <= PinReleased;
            sync2_q <= PinReleased;
        end else begin
            sync1_q <= button_raw;
            sync2_q <= sync1_q;
        end
    end

    assign norm = sync2_q ^ ACTIVE_LOW;

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive mismatches.
    always_comb begin
        pressed_d = pressed_q;
        deb_cnt_d = deb_cnt_q;
        if (norm == pressed_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DebLast) begin
            pressed_d = norm;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    // Edge pulses are registered with the level so they cover its first cycle.
    always_comb begin
        press_pulse_d   = pressed_d & ~pressed_q;
        release_pulse_d = ~pressed_d & pressed_q;
    end

    // Hold counter: number of cycles pressed has been high, counting the first as 1.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (!pressed_d) begin
            hold_cnt_d = '0;
        end else if (!pressed_q) begin
            hold_cnt_d = HoldOne;
        end else if (hold_cnt_q != HoldMax) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    // Long-press level and its one-shot rising-edge pulse.
    always_comb begin
        long_held_d  = pressed_d && (hold_cnt_d == HoldMax);
        long_pulse_d = long_held_d && !long_held_q;
    end

    // Debounce and output state; reset drops everything without a release pulse.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            deb_cnt_q       <= '0;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            hold_cnt_q      <= '0;
            long_pulse_q    <= 1'b0;
            long_held_q     <= 1'b0;
        end else begin
            deb_cnt_q       <= deb_cnt_d;
            pressed_q       <= pressed_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            hold_cnt_q      <= hold_cnt_d;
            long_pulse_q    <= long_pulse_d;
            long_held_q     <= long_held_d;
        end
    end

    assign pressed          = pressed_q;
    assign press_pulse      = press_pulse_q;
    assign release_pulse    = release_pulse_q;
    assign long_press_pulse = long_pulse_q;
    assign long_held        = long_held_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with a window-based reference model.
module tb_button_conditioner;

    localparam bit          AL  = 1'b1;
    localparam int unsigned DEB = 8;
    localparam int unsigned LP  = 32;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    logic button_raw = 1'b1;
    logic pressed, press_pulse, release_pulse, long_press_pulse, long_held;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state
    logic q_hist[$];
    logic m_pressed, m_pp, m_rp, m_lpp, m_lh;
    int   m_hold;

    wire [4:0] obs   = {pressed, press_pulse, release_pulse, long_press_pulse, long_held};
    wire [4:0] exp_v = {m_pressed, m_pp, m_rp, m_lpp, m_lh};

    button_conditioner #(
        .ACTIVE_LOW       (AL),
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_PRESS_CYCLES(LP)
    ) dut (
        .clk_in          (clk_in),
        .reset           (reset),
        .button_raw      (button_raw),
        .pressed         (pressed),
        .press_pulse     (press_pulse),
        .release_pulse   (release_pulse),
        .long_press_pulse(long_press_pulse),
        .long_held       (long_held)
    );

    always #4 clk_in = ~clk_in;

    task automatic model_reset();
        q_hist.delete();
        for (int i = 0; i < 2 * DEB + 4; i++) q_hist.push_back(AL);
        m_pressed = 1'b0; m_pp = 1'b0; m_rp = 1'b0; m_lpp = 1'b0; m_lh = 1'b0;
        m_hold = 0;
    endtask

    // A level change is accepted when the DEB most recent checked samples (raw values
    // taken 2..DEB+1 edges ago) all disagree with the current debounced level.
    task automatic model_edge(input logic raw);
        int   s;
        bit   all_mis;
        logic old;
        q_hist.push_back(raw);
        while (q_hist.size() > 40) void'(q_hist.pop_front());
        s = q_hist.size();
        all_mis = 1'b1;
        for (int i = s - 2 - int'(DEB); i <= s - 3; i++)
            if ((q_hist[i] ^ AL) == m_pressed) all_mis = 1'b0;
        old = m_pressed;
        if (all_mis) m_pressed = ~m_pressed;
        m_pp   = m_pressed & ~old;
        m_rp   = ~m_pressed & old;
        m_hold = m_pressed ? m_hold + 1 : 0;
        m_lpp  = m_pressed && (m_hold == int'(LP));
        m_lh   = m_pressed && (m_hold >= int'(LP));
    endtask

    // Drive one cycle: input set at negedge, model advanced at posedge, return at negedge.
    task automatic tick(input logic raw);
        button_raw = raw;
        @(posedge clk_in);
        cyc++;
        if (reset) model_reset();
        else model_edge(raw);
        @(negedge clk_in);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        button_raw = 1'b1;
        model_reset();
        repeat (3) @(negedge clk_in);
        checks++;
        if (obs !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs obs=%b exp=%b", obs, 5'b0);
        end
        reset = 1'b0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 50; i++) begin
            tick(1'b1);
            checks++;
            if (obs !== 5'b0 || obs !== exp_v) begin
                failures++;
                $display("FAIL idle cyc=%0d obs=%b exp=%b", cyc, obs, exp_v);
            end
        end
    endtask

    task automatic test_press_latency();
        int k;
        int rise_at = -1;
        int pp_n = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0);
            if (i == 0) k = cyc;
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL press_model cyc=%0d obs=%b exp=%b", cyc, obs, exp_v);
            end
            if (press_pulse) pp_n++;
            if (pressed && rise_at < 0) rise_at = cyc;
        end
        checks++;
        if (rise_at !== k + 9) begin
            failures++;
            $display("FAIL press_latency rise_at=%0d exp=%0d", rise_at, k + 9);
        end
        checks++;
        if (pp_n !== 1) begin
            failures++;
            $display("FAIL press_pulse_count got=%0d exp=1", pp_n);
        end
        // release and settle
        for (int i = 0; i < 20; i++) tick(1'b1);
    endtask

    task automatic test_bounce();
        logic pat[$];
        bit   any_out = 1'b0;
        for (int i = 0; i < 5; i++) pat.push_back(1'b0);
        for (int i = 0; i < 2; i++) pat.push_back(1'b1);
        for (int i = 0; i < 7; i++) pat.push_back(1'b0);
        for (int i = 0; i < 20; i++) pat.push_back(1'b1);
        foreach (pat[i]) begin
            tick(pat[i]);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL bounce_model cyc=%0d obs=%b exp=%b", cyc, obs, exp_v);
            end
            if (obs != 5'b0) any_out = 1'b1;
        end
        checks++;
        if (any_out !== 1'b0) begin
            failures++;
            $display("FAIL bounce_quiet got=%0b exp=0", any_out);
        end
    endtask

    task automatic test_long_press();
        int pcount = 0;
        int lp_n = 0;
        int lp_at = -1;
        int k;
        int rel_at = -1;
        logic lh_at_rel = 1'b1;
        for (int i = 0; i < 70 && pcount < 40; i++) begin
            tick(1'b0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL long_model cyc=%0d obs=%b exp=%b", cyc, obs, exp_v);
            end
            if (pcount > 0 || press_pulse) pcount++;
            if (long_press_pulse) begin
                lp_n++;
                lp_at = pcount;
            end
        end
        checks++;
        if (lp_n !== 1 || lp_at !== int'(LP)) begin
            failures++;
            $display("FAIL long_pulse count=%0d at=%0d exp count=1 at=%0d", lp_n, lp_at, LP);
        end
        checks++;
        if (long_held !== 1'b1) begin
            failures++;
            $display("FAIL long_held_level got=%b exp=1", long_held);
        end
        for (int i = 0; i < 20; i++) begin
            tick(1'b1);
            if (i == 0) k = cyc;
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL long_release_model cyc=%0d obs=%b exp=%b", cyc, obs, exp_v);
            end
            if (release_pulse && rel_at < 0) begin
                rel_at = cyc;
                lh_at_rel = long_held;
            end
        end
        checks++;
        if (rel_at !== k + 9 || lh_at_rel !== 1'b0) begin
            failures++;
            $display("FAIL long_release at=%0d held=%b exp at=%0d held=0",
                     rel_at, lh_at_rel, k + 9);
        end
    endtask

    task automatic test_short_press();
        int pp_n = 0, rp_n = 0, lp_n = 0, held = 0;
        for (int i = 0; i < 40 && held < 20; i++) begin
            tick(1'b0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL short_model cyc=%0d obs=%b exp=%b", cyc, obs, exp_v);
            end
            if (pressed) held++;
            pp_n += int'(press_pulse); rp_n += int'(release_pulse); lp_n += int'(long_press_pulse);
        end
        for (int i = 0; i < 20; i++) begin
            tick(1'b1);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL short_release_model cyc=%0d obs=%b exp=%b", cyc, obs, exp_v);
            end
            pp_n += int'(press_pulse); rp_n += int'(release_pulse); lp_n += int'(long_press_pulse);
        end
        checks++;
        if (pp_n !== 1 || rp_n !== 1 || lp_n !== 0) begin
            failures++;
            $display("FAIL short_counts press=%0d release=%0d long=%0d exp 1 1 0",
                     pp_n, rp_n, lp_n);
        end
    endtask

    task automatic test_reset_mid_press();
        int k;
        int pp_at = -1;
        bit rel_seen = 1'b0;
        for (int i = 0; i < 45; i++) begin
            tick(1'b0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL midrst_model cyc=%0d obs=%b exp=%b", cyc, obs, exp_v);
            end
        end
        checks++;
        if (pressed !== 1'b1 || long_held !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre pressed=%b long_held=%b exp 1 1", pressed, long_held);
        end
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (obs !== 5'b0) begin
            failures++;
            $display("FAIL midrst_async obs=%b exp=%b", obs, 5'b0);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0);
            checks++;
            if (obs !== 5'b0) begin
                failures++;
                $display("FAIL midrst_hold cyc=%0d obs=%b exp=%b", cyc, obs, 5'b0);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0);
            if (i == 0) k = cyc;
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL midrst_after cyc=%0d obs=%b exp=%b", cyc, obs, exp_v);
            end
            if (press_pulse && pp_at < 0) pp_at = cyc;
            if (release_pulse) rel_seen = 1'b1;
        end
        checks++;
        if (pp_at !== k + 9 || rel_seen !== 1'b0) begin
            failures++;
            $display("FAIL midrst_repress at=%0d rel=%b exp at=%0d rel=0", pp_at, rel_seen, k + 9);
        end
        for (int i = 0; i < 20; i++) tick(1'b1);
    endtask

    task automatic test_random();
        int n = 0;
        while (n < 2000) begin
            logic v;
            int   len;
            v = 1'($urandom_range(0, 1));
            if (!v && $urandom_range(0, 3) == 0) len = $urandom_range(30, 45);
            else len = $urandom_range(1, 14);
            for (int i = 0; i < len; i++) begin
                tick(v);
                n++;
                checks++;
                if (obs !== exp_v) begin
                    failures++;
                    $display("FAIL random cyc=%0d obs=%b exp=%b", cyc, obs, exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_press_latency();
        test_bounce();
        test_long_press();
        test_short_press();
        test_reset_mid_press();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
